// File: rtl/fog_pkg.sv
// Shared types and helpers for the FOG loop sequencer.
package fog_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_CAL       = 3'd2,
        ST_ENGAGE    = 3'd3,
        ST_GAIN_STEP = 3'd4,
        ST_LOCK_WAIT = 3'd5,
        ST_LOCKED    = 3'd6,
        ST_FAULT     = 3'd7
    } state_e;

    // Magnitude of a signed word; the most negative value saturates to max positive.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (x[DATA_W-1]) begin
            r = DATA_W'(-x);
        end else begin
            r = DATA_W'(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/fog_period_counter.sv
// Saturating event counter with clear; flags the increment that reaches the terminal count.
module fog_period_counter
    import fog_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [DATA_W-1:0] term_i,
    output logic              hit_c_o
);

    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] count_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + DATA_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of clr_i so the FSM may derive its clear from this flag.
    assign hit_c_o = inc_i &&
                     (((DATA_W+1)'(count_q) + (DATA_W+1)'(1)) >= (DATA_W+1)'(term_i));

endmodule

// File: rtl/fog_loop_sequencer.sv
// Bring-up, calibration, gain scheduling and lock supervision for the FOG loop.
module fog_loop_sequencer
    import fog_pkg::*;
#(
    parameter int unsigned SETTLE_PERIODS  = 64,
    parameter int unsigned CAL_LOG2        = 10,
    parameter int unsigned GAIN_START      = 12,
    parameter int unsigned GAIN_HOLD       = 256,
    parameter int unsigned LOCK_CNT        = 16,
    parameter int unsigned FAULT_CNT       = 8,
    parameter int unsigned TIMEOUT_PERIODS = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_rate_sync,
    input  logic [31:0] i_err,
    input  logic [31:0] i_gain_final,
    input  logic [31:0] i_lock_thr,
    input  logic [31:0] i_fault_thr,
    output logic        o_mod_en,
    output logic [31:0] o_fb_ON,
    output logic [31:0] o_gain_sel,
    output logic [31:0] o_err_offset,
    output logic        o_locked,
    output logic        o_fault,
    output logic [2:0]  o_state
);

    localparam int unsigned       ACC_W       = DATA_W + CAL_LOG2;
    localparam logic [DATA_W-1:0] GAIN_INIT   = DATA_W'(GAIN_START);
    localparam logic [DATA_W-1:0] SETTLE_TERM = DATA_W'(SETTLE_PERIODS);
    localparam logic [DATA_W-1:0] CAL_TERM    = DATA_W'(64'd1 << CAL_LOG2);
    localparam logic [DATA_W-1:0] HOLD_TERM   = DATA_W'(GAIN_HOLD);
    localparam logic [DATA_W-1:0] TOUT_TERM   = DATA_W'(TIMEOUT_PERIODS);
    localparam logic [DATA_W-1:0] LOCK_TERM   = DATA_W'(LOCK_CNT);
    localparam logic [DATA_W-1:0] FAULT_TERM  = DATA_W'(FAULT_CNT);

    state_e                    state_q, state_d;
    logic                      rate_q;
    logic                      pulse_c;
    logic [DATA_W-1:0]         err_abs_c;
    logic                      mod_en_q, mod_en_d;
    logic                      fb_on_q, fb_on_d;
    logic                      locked_q, locked_d;
    logic                      fault_q, fault_d;
    logic [DATA_W-1:0]         gain_q, gain_d;
    logic signed [DATA_W-1:0]  offset_q, offset_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum_c;
    logic                      per_inc_c, per_clr_c, per_hit_c;
    logic [DATA_W-1:0]         per_term_c;
    logic                      run_inc_c, run_clr_c, run_hit_c, run_cond_c;
    logic [DATA_W-1:0]         run_term_c;

    assign pulse_c   = i_rate_sync && !rate_q;
    assign err_abs_c = abs_sat(i_err);
    assign acc_sum_c = acc_q + ACC_W'($signed(i_err));

    // Period counter: settle, calibration, gain hold and lock timeout.
    fog_period_counter u_per_cnt (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .clr_i   (per_clr_c),
        .inc_i   (per_inc_c),
        .term_i  (per_term_c),
        .hit_c_o (per_hit_c)
    );

    // Consecutive-sample counter: lock qualification and fault detection.
    fog_period_counter u_run_cnt (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .clr_i   (run_clr_c),
        .inc_i   (run_inc_c),
        .term_i  (run_term_c),
        .hit_c_o (run_hit_c)
    );

    // Counter increment/terminal selection from the current state.
    always_comb begin
        per_inc_c  = 1'b0;
        per_term_c = TOUT_TERM;
        run_cond_c = 1'b0;
        run_term_c = LOCK_TERM;
        case (state_q)
            ST_SETTLE:    begin per_inc_c = pulse_c; per_term_c = SETTLE_TERM; end
            ST_CAL:       begin per_inc_c = pulse_c; per_term_c = CAL_TERM;    end
            ST_GAIN_STEP: begin per_inc_c = pulse_c; per_term_c = HOLD_TERM;   end
            ST_LOCK_WAIT: begin
                per_inc_c  = pulse_c;
                per_term_c = TOUT_TERM;
                run_cond_c = err_abs_c < i_lock_thr;
            end
            ST_LOCKED: begin
                run_cond_c = err_abs_c >= i_fault_thr;
                run_term_c = FAULT_TERM;
            end
            default: ;
        endcase
        run_inc_c = pulse_c && run_cond_c;
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            rate_q   <= 1'b0;
            mod_en_q <= 1'b0;
            fb_on_q  <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            gain_q   <= GAIN_INIT;
            offset_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            rate_q   <= i_rate_sync;
            mod_en_q <= mod_en_d;
            fb_on_q  <= fb_on_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            gain_q   <= gain_d;
            offset_q <= offset_d;
            acc_q    <= acc_d;
        end
    end

    // Next-state logic; dropping i_start overrides everything.
    always_comb begin
        state_d = state_q;
        if (!i_start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_SETTLE;
                ST_SETTLE:    if (per_hit_c) state_d = ST_CAL;
                ST_CAL:       if (per_hit_c) state_d = ST_ENGAGE;
                ST_ENGAGE:    state_d = ST_GAIN_STEP;
                ST_GAIN_STEP: begin
                    if (i_gain_final >= gain_q) begin
                        state_d = ST_LOCK_WAIT;
                    end else if (per_hit_c && ((gain_q - DATA_W'(1)) <= i_gain_final)) begin
                        state_d = ST_LOCK_WAIT;
                    end
                end
                ST_LOCK_WAIT: begin
                    if (run_hit_c) begin
                        state_d = ST_LOCKED;
                    end else if (per_hit_c) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_LOCKED:    if (run_hit_c) state_d = ST_FAULT;
                ST_FAULT:     state_d = ST_FAULT;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Output, accumulator and counter-clear logic.
    always_comb begin
        mod_en_d  = state_d != ST_IDLE;
        fb_on_d   = state_d inside {ST_ENGAGE, ST_GAIN_STEP, ST_LOCK_WAIT, ST_LOCKED};
        locked_d  = state_d == ST_LOCKED;
        fault_d   = state_d == ST_FAULT;
        gain_d    = gain_q;
        offset_d  = offset_q;
        acc_d     = acc_q;
        per_clr_c = (state_q == ST_IDLE) || (state_d != state_q) ||
                    ((state_q == ST_GAIN_STEP) && per_hit_c);
        run_clr_c = (state_q == ST_IDLE) || (state_d != state_q) ||
                    (pulse_c && !run_cond_c);

        if ((state_d == ST_IDLE) || (state_d == ST_ENGAGE)) begin
            gain_d = GAIN_INIT;
        end else if ((state_q == ST_GAIN_STEP) && per_hit_c && (i_gain_final < gain_q)) begin
            gain_d = gain_q - DATA_W'(1);
        end

        if ((state_d == ST_CAL) && (state_q != ST_CAL)) begin
            acc_d = '0;
        end else if ((state_q == ST_CAL) && pulse_c) begin
            acc_d = acc_sum_c;
            if (state_d == ST_ENGAGE) begin
                offset_d = DATA_W'(acc_sum_c >>> CAL_LOG2);
            end
        end
    end

    assign o_mod_en     = mod_en_q;
    assign o_fb_ON      = {{(DATA_W-1){1'b0}}, fb_on_q};
    assign o_gain_sel   = gain_q;
    assign o_err_offset = offset_q;
    assign o_locked     = locked_q;
    assign o_fault      = fault_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_fog_loop_sequencer.sv
// Directed scoreboard bench for fog_loop_sequencer.
module tb_fog_loop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rate_sync;
    logic [31:0] err;
    logic [31:0] gain_final;
    logic [31:0] lock_thr;
    logic [31:0] fault_thr;
    logic        mod_en;
    logic [31:0] fb_on;
    logic [31:0] gain_sel;
    logic [31:0] err_offset;
    logic        locked;
    logic        fault;
    logic [2:0]  state;

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    fog_loop_sequencer #(
        .SETTLE_PERIODS  (4),
        .CAL_LOG2        (2),
        .GAIN_START      (12),
        .GAIN_HOLD       (2),
        .LOCK_CNT        (16),
        .FAULT_CNT       (8),
        .TIMEOUT_PERIODS (200)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_rate_sync  (rate_sync),
        .i_err        (err),
        .i_gain_final (gain_final),
        .i_lock_thr   (lock_thr),
        .i_fault_thr  (fault_thr),
        .o_mod_en     (mod_en),
        .o_fb_ON      (fb_on),
        .o_gain_sel   (gain_sel),
        .o_err_offset (err_offset),
        .o_locked     (locked),
        .o_fault      (fault),
        .o_state      (state)
    );

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_total++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty, observed=0x%08h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) begin
                n_pass++;
            end else begin
                n_fail++;
                $error("FAIL %s observed=0x%08h expected=0x%08h", t, obs, e);
            end
        end
    endtask

    task automatic expect_outs(input string tag, input logic [2:0] st, input logic me,
                               input logic fb, input logic [31:0] g, input logic lk,
                               input logic fl);
        push({tag, ".state"},  32'(st));
        push({tag, ".mod_en"}, 32'(me));
        push({tag, ".fb_on"},  32'(fb));
        push({tag, ".gain"},   g);
        push({tag, ".locked"}, 32'(lk));
        push({tag, ".fault"},  32'(fl));
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".state"},  32'(state));
        check({tag, ".mod_en"}, 32'(mod_en));
        check({tag, ".fb_on"},  fb_on);
        check({tag, ".gain"},   gain_sel);
        check({tag, ".locked"}, 32'(locked));
        check({tag, ".fault"},  32'(fault));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One idle cycle, then rate_sync high for len cycles with err held.
    task automatic pulse(input logic [31:0] e, input int len);
        tick(1);
        err       = e;
        rate_sync = 1'b1;
        tick(len);
        rate_sync = 1'b0;
    endtask

    initial begin
        logic [31:0] eg;
        logic [31:0] cal_run1 [4];
        cal_run1[0] = 32'hFFFF_FFFD;
        cal_run1[1] = 32'hFFFF_FFFE;
        cal_run1[2] = 32'hFFFF_FFFE;
        cal_run1[3] = 32'hFFFF_FFFE;

        rst        = 1'b1;
        start      = 1'b0;
        rate_sync  = 1'b0;
        err        = '0;
        gain_final = 32'd9;
        lock_thr   = 32'd10;
        fault_thr  = 32'h8000_0000;

        // Reset values.
        expect_outs("reset", 3'd0, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0);
        push("reset.offset", 32'd0);
        tick(2);
        check_outs("reset");
        check("reset.offset", err_offset);
        rst = 1'b0;
        tick(1);

        // Start: SETTLE one cycle later.
        start = 1'b1;
        expect_outs("start", 3'd1, 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
        tick(1);
        check_outs("start");

        // Settle: first pulse stretched over three cycles still counts once.
        for (int i = 0; i < 4; i++) begin
            expect_outs("settle", (i == 3) ? 3'd2 : 3'd1, 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
            pulse(32'd100, (i == 0) ? 3 : 1);
            check_outs("settle");
        end

        // Calibration: -3,-2,-2,-2 averages to floor(-9/4) = -3.
        for (int i = 0; i < 4; i++) begin
            expect_outs("cal", (i == 3) ? 3'd3 : 3'd2, 1'b1, (i == 3), 32'd12, 1'b0, 1'b0);
            pulse(cal_run1[i], 1);
            check_outs("cal");
        end
        push("cal.offset", 32'hFFFF_FFFD);
        check("cal.offset", err_offset);

        expect_outs("engage", 3'd4, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
        tick(1);
        check_outs("engage");

        // Gain schedule 12 -> 9 with two pulses per step.
        eg = 32'd12;
        for (int p = 1; p <= 6; p++) begin
            if ((p % 2) == 0) eg = eg - 32'd1;
            expect_outs("gain", (eg == 32'd9) ? 3'd5 : 3'd4, 1'b1, 1'b1, eg, 1'b0, 1'b0);
            pulse(32'd5, 1);
            check_outs("gain");
        end

        // Lock wait: |err| == thr at sample 10 is a miss; lock 16 samples later.
        for (int k = 1; k <= 26; k++) begin
            expect_outs("lockwait", (k == 26) ? 3'd6 : 3'd5, 1'b1, 1'b1, 32'd9, (k == 26), 1'b0);
            pulse((k == 10) ? 32'hFFFF_FFF6 : 32'd5, 1);
            check_outs("lockwait");
        end

        // |-2^31| saturates below a 2^31 threshold: no fault.
        for (int k = 0; k < 8; k++) begin
            expect_outs("abs_sat", 3'd6, 1'b1, 1'b1, 32'd9, 1'b1, 1'b0);
            pulse(32'h8000_0000, 1);
            check_outs("abs_sat");
        end

        // Fault run with one in-threshold sample resetting the count.
        fault_thr = 32'd1000;
        for (int k = 1; k <= 12; k++) begin
            if (k == 12) expect_outs("fault", 3'd7, 1'b1, 1'b0, 32'd9, 1'b0, 1'b1);
            else         expect_outs("fault", 3'd6, 1'b1, 1'b1, 32'd9, 1'b1, 1'b0);
            pulse((k == 4) ? 32'd999 : 32'h8000_0000, 1);
            check_outs("fault");
        end

        // Fault is latched.
        for (int k = 0; k < 2; k++) begin
            expect_outs("fault_hold", 3'd7, 1'b1, 1'b0, 32'd9, 1'b0, 1'b1);
            pulse(32'd0, 1);
            check_outs("fault_hold");
        end

        // Stop: IDLE, offset retained.
        start = 1'b0;
        expect_outs("stop", 3'd0, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0);
        push("stop.offset", 32'hFFFF_FFFD);
        tick(1);
        check_outs("stop");
        check("stop.offset", err_offset);

        // Second run: constant 100 calibrates to 100; final gain >= start skips stepping.
        gain_final = 32'd12;
        start = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) pulse(32'd100, 1);
        expect_outs("run2.settle", 3'd2, 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
        check_outs("run2.settle");
        for (int i = 0; i < 4; i++) pulse(32'd100, 1);
        push("run2.offset", 32'd100);
        check("run2.offset", err_offset);
        expect_outs("run2.engage", 3'd3, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
        check_outs("run2.engage");
        expect_outs("run2.gstep", 3'd4, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
        tick(1);
        check_outs("run2.gstep");
        expect_outs("run2.lwait", 3'd5, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
        tick(1);
        check_outs("run2.lwait");

        // Timeout after 200 pulses without lock.
        for (int k = 0; k < 199; k++) pulse(32'd1000, 1);
        expect_outs("timeout.pre", 3'd5, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
        check_outs("timeout.pre");
        expect_outs("timeout", 3'd7, 1'b1, 1'b0, 32'd12, 1'b0, 1'b1);
        pulse(32'd1000, 1);
        check_outs("timeout");

        // Third run: reset during GAIN_STEP returns everything to reset values.
        start = 1'b0;
        tick(1);
        gain_final = 32'd9;
        start = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) pulse(32'd7, 1);
        tick(1);
        expect_outs("run3.gstep", 3'd4, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
        push("run3.offset", 32'd7);
        pulse(32'd0, 1);
        check_outs("run3.gstep");
        check("run3.offset", err_offset);
        rst = 1'b1;
        expect_outs("midrst", 3'd0, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0);
        push("midrst.offset", 32'd0);
        tick(1);
        check_outs("midrst");
        check("midrst.offset", err_offset);
        rst = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
